// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, ALU operation encodings,
// branch condition codes and the controller state enum.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] OPC_ADD = 4'h0;
    localparam logic [3:0] OPC_ADC = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_SBC = 4'h3;
    localparam logic [3:0] OPC_AND = 4'h4;
    localparam logic [3:0] OPC_OR  = 4'h5;
    localparam logic [3:0] OPC_XOR = 4'h6;
    localparam logic [3:0] OPC_NOT = 4'h7;
    localparam logic [3:0] OPC_INC = 4'h8;
    localparam logic [3:0] OPC_DEC = 4'h9;
    localparam logic [3:0] OPC_SHR = 4'hA;
    localparam logic [3:0] OPC_RCR = 4'hB;
    localparam logic [3:0] OPC_SHL = 4'hC;
    localparam logic [3:0] OPC_RCL = 4'hD;
    localparam logic [3:0] OPC_CMP = 4'hE;
    localparam logic [3:0] OPC_JCC = 4'hF;

    localparam logic [4:0] AOP_NOP = 5'b00000;
    localparam logic [4:0] AOP_ADD = 5'b01000;
    localparam logic [4:0] AOP_ADC = 5'b01010;
    localparam logic [4:0] AOP_SUB = 5'b01011;
    localparam logic [4:0] AOP_SBC = 5'b01101;
    localparam logic [4:0] AOP_INC = 5'b01110;
    localparam logic [4:0] AOP_DEC = 5'b01111;
    localparam logic [4:0] AOP_AND = 5'b10000;
    localparam logic [4:0] AOP_OR  = 5'b10001;
    localparam logic [4:0] AOP_XOR = 5'b10010;
    localparam logic [4:0] AOP_NOT = 5'b10011;
    localparam logic [4:0] AOP_SHR = 5'b11000;
    localparam logic [4:0] AOP_RCR = 5'b11001;
    localparam logic [4:0] AOP_RCL = 5'b11010;
    localparam logic [4:0] AOP_SHL = 5'b11011;

    localparam logic [2:0] CC_ALWAYS = 3'd0;
    localparam logic [2:0] CC_Z      = 3'd1;
    localparam logic [2:0] CC_NZ     = 3'd2;
    localparam logic [2:0] CC_C      = 3'd3;
    localparam logic [2:0] CC_NC     = 3'd4;
    localparam logic [2:0] CC_S      = 3'd5;
    localparam logic [2:0] CC_NS     = 3'd6;
    localparam logic [2:0] CC_NEVER  = 3'd7;

    // Bit positions inside the {S,Z,Cy} flag vector
    localparam int FLG_CY = 0;
    localparam int FLG_Z  = 1;
    localparam int FLG_S  = 2;

    function automatic logic [4:0] opc_to_aluop(input logic [3:0] opc);
        logic [4:0] aop;
        case (opc)
            OPC_ADD: aop = AOP_ADD;
            OPC_ADC: aop = AOP_ADC;
            OPC_SUB: aop = AOP_SUB;
            OPC_SBC: aop = AOP_SBC;
            OPC_AND: aop = AOP_AND;
            OPC_OR:  aop = AOP_OR;
            OPC_XOR: aop = AOP_XOR;
            OPC_NOT: aop = AOP_NOT;
            OPC_INC: aop = AOP_INC;
            OPC_DEC: aop = AOP_DEC;
            OPC_SHR: aop = AOP_SHR;
            OPC_RCR: aop = AOP_RCR;
            OPC_SHL: aop = AOP_SHL;
            OPC_RCL: aop = AOP_RCL;
            OPC_CMP: aop = AOP_SUB;
            default: aop = AOP_NOP;
        endcase
        return aop;
    endfunction

endpackage

// File: rtl/alu_cond.sv
// Branch condition evaluator: decides whether a JCC is taken from the
// current {S,Z,Cy} flags.
module alu_cond
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] i_flags,
    input  logic [2:0] i_cond,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            CC_ALWAYS: o_taken = 1'b1;
            CC_Z:      o_taken = i_flags[FLG_Z];
            CC_NZ:     o_taken = ~i_flags[FLG_Z];
            CC_C:      o_taken = i_flags[FLG_CY];
            CC_NC:     o_taken = ~i_flags[FLG_CY];
            CC_S:      o_taken = i_flags[FLG_S];
            CC_NS:     o_taken = ~i_flags[FLG_S];
            CC_NEVER:  o_taken = 1'b0;
            default:   o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Request/response sequencer that drives an external combinational ALU for one
// cycle per instruction and keeps the architectural {S,Z,Cy} flag register.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_opc,
    input  logic [2:0] req_cond,
    input  logic [7:0] req_x,
    input  logic [7:0] req_t,
    output logic [7:0] alu_x,
    output logic [7:0] alu_t,
    output logic       alu_cy,
    output logic [4:0] alu_op,
    input  logic [2:0] alu_flag,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_taken,
    output logic [2:0] flags,
    input  logic       flag_clr
);

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_opc;
    logic [2:0] r_cond;
    logic [7:0] r_x;
    logic [7:0] r_t;
    logic [7:0] r_result;
    logic       r_taken;
    logic [2:0] r_flags;
    logic       w_accept;
    logic       w_exec_end;
    logic       w_taken;

    assign w_accept   = req_valid && req_ready;
    assign w_exec_end = (r_state == EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ALU drive is decoded from state so reset zeroes it without waiting for a clock
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_op       = AOP_NOP;
        alu_x        = 8'h00;
        alu_t        = 8'h00;
        alu_cy       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                alu_op       = opc_to_aluop(r_opc);
                alu_x        = r_x;
                alu_t        = r_t;
                alu_cy       = r_flags[FLG_CY];
                w_state_next = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opc  <= 4'h0;
            r_cond <= 3'd0;
            r_x    <= 8'h00;
            r_t    <= 8'h00;
        end else if (w_accept) begin
            r_opc  <= req_opc;
            r_cond <= req_cond;
            r_x    <= req_x;
            r_t    <= req_t;
        end
    end

    // Condition is judged on the flags as they stood before this instruction
    alu_cond u_alu_cond (
        .i_flags (r_flags),
        .i_cond  (r_cond),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= 8'h00;
            r_taken  <= 1'b0;
            r_flags  <= 3'b000;
        end else begin
            if (w_exec_end) begin
                if ((r_opc != OPC_CMP) && (r_opc != OPC_JCC)) begin
                    r_result <= alu_result;
                end
                r_taken <= (r_opc == OPC_JCC) ? w_taken : 1'b0;
            end
            if (flag_clr) begin
                r_flags <= 3'b000;
            end else if (w_exec_end && (r_opc != OPC_JCC)) begin
                r_flags <= alu_flag;
            end
        end
    end

    assign rsp_result = r_result;
    assign rsp_taken  = r_taken;
    assign flags      = r_flags;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: a behavioural ALU answers the controller, and a reference
// model pushes expected responses into a scoreboard popped at each response.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_opc = 4'h0;
    logic [2:0] req_cond = 3'd0;
    logic [7:0] req_x = 8'h00;
    logic [7:0] req_t = 8'h00;
    logic [7:0] alu_x;
    logic [7:0] alu_t;
    logic       alu_cy;
    logic [4:0] alu_op;
    logic [2:0] alu_flag;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_taken;
    logic [2:0] flags;
    logic       flag_clr = 1'b0;

    typedef struct packed {
        logic [7:0] result;
        logic       taken;
        logic [2:0] flags;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [2:0]  mdl_flags = 3'b000;
    logic [7:0]  mdl_result = 8'h00;
    logic [10:0] alu_rsp;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opc    (req_opc),
        .req_cond   (req_cond),
        .req_x      (req_x),
        .req_t      (req_t),
        .alu_x      (alu_x),
        .alu_t      (alu_t),
        .alu_cy     (alu_cy),
        .alu_op     (alu_op),
        .alu_flag   (alu_flag),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_taken  (rsp_taken),
        .flags      (flags),
        .flag_clr   (flag_clr)
    );

    // Behavioural ALU: returns {S,Z,Cy,result}; carry on subtract means "no borrow"
    function automatic logic [10:0] alu_f(input logic [4:0] op, input logic [7:0] x,
                                          input logic [7:0] t, input logic cy);
        logic [8:0] w;
        w = 9'd0;
        case (op)
            5'b01000: w = {1'b0, x} + {1'b0, t};
            5'b01010: w = {1'b0, x} + {1'b0, t} + {8'd0, cy};
            5'b01011: w = {1'b0, x} + {1'b0, ~t} + 9'd1;
            5'b01101: w = {1'b0, x} + {1'b0, ~t} + {8'd0, cy};
            5'b01110: w = {1'b0, x} + 9'd1;
            5'b01111: w = {1'b0, x} + 9'h0FF;
            5'b10000: w = {1'b0, x & t};
            5'b10001: w = {1'b0, x | t};
            5'b10010: w = {1'b0, x ^ t};
            5'b10011: w = {1'b0, ~x};
            5'b11000: w = {x[0], 1'b0, x[7:1]};
            5'b11001: w = {x[0], cy, x[7:1]};
            5'b11011: w = {x[7], x[6:0], 1'b0};
            5'b11010: w = {x[7], x[6:0], cy};
            default:  w = 9'd0;
        endcase
        return {w[7], (w[7:0] == 8'h00), w[8], w[7:0]};
    endfunction

    function automatic logic [4:0] exp_aluop(input logic [3:0] opc);
        logic [4:0] a;
        case (opc)
            4'h0: a = 5'b01000;
            4'h1: a = 5'b01010;
            4'h2: a = 5'b01011;
            4'h3: a = 5'b01101;
            4'h4: a = 5'b10000;
            4'h5: a = 5'b10001;
            4'h6: a = 5'b10010;
            4'h7: a = 5'b10011;
            4'h8: a = 5'b01110;
            4'h9: a = 5'b01111;
            4'hA: a = 5'b11000;
            4'hB: a = 5'b11001;
            4'hC: a = 5'b11011;
            4'hD: a = 5'b11010;
            4'hE: a = 5'b01011;
            default: a = 5'b00000;
        endcase
        return a;
    endfunction

    function automatic logic cond_eval(input logic [2:0] c, input logic [2:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[1];
            3'd2: return ~f[1];
            3'd3: return f[0];
            3'd4: return ~f[0];
            3'd5: return f[2];
            3'd6: return ~f[2];
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_rsp    = alu_f(alu_op, alu_x, alu_t, alu_cy);
        alu_result = alu_rsp[7:0];
        alu_flag   = alu_rsp[10:8];
    end

    // Issue one instruction, check its drive/latency/backpressure and pop its response.
    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_op(input logic [3:0] opc, input logic [2:0] cond, input logic [7:0] x,
                          input logic [7:0] t, input int hold, input bit clr);
        exp_t        e;
        exp_t        got;
        logic [4:0]  aop;
        logic [10:0] r;
        logic        pre_cy;
        int          n;
        req_opc   = opc;
        req_cond  = cond;
        req_x     = x;
        req_t     = t;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout opc=%h req_ready=%b required 1", opc, req_ready);
            req_valid = 1'b0;
            return;
        end
        aop    = exp_aluop(opc);
        pre_cy = mdl_flags[0];
        r      = alu_f(aop, x, t, pre_cy);
        e.taken = (opc == 4'hF) ? cond_eval(cond, mdl_flags) : 1'b0;
        if (opc <= 4'hD) mdl_result = r[7:0];
        if (clr) mdl_flags = 3'b000;
        else if (opc != 4'hF) mdl_flags = r[10:8];
        e.result = mdl_result;
        e.flags  = mdl_flags;
        sb.push_back(e);

        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_in_accept_cycle opc=%h rsp_valid=%b required 0", opc, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_x     = 8'($urandom);
        req_t     = 8'($urandom);
        req_opc   = 4'($urandom);
        req_cond  = 3'($urandom);
        @(negedge clk);
        total++;
        if ({alu_op, alu_x, alu_t, alu_cy, rsp_valid} !== {aop, x, t, pre_cy, 1'b0}) begin
            bad++;
            $display("FAIL exec_drive opc=%h got op=%b x=%h t=%h cy=%b valid=%b required op=%b x=%h t=%h cy=%b valid=0",
                     opc, alu_op, alu_x, alu_t, alu_cy, rsp_valid, aop, x, t, pre_cy);
        end
        if (clr) flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        @(negedge clk);
        total++;
        if ({rsp_valid, req_ready, alu_op, alu_x, alu_t, alu_cy} !== {2'b10, 5'b0, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL done_state opc=%h got valid=%b ready=%b op=%b x=%h t=%h cy=%b required valid=1 ready=0 and idle ALU drive",
                     opc, rsp_valid, req_ready, alu_op, alu_x, alu_t, alu_cy);
        end
        got = {rsp_result, rsp_taken, flags};
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({rsp_valid, req_ready, rsp_result, rsp_taken, flags} !== {2'b10, got}) begin
                bad++;
                $display("FAIL hold_stable opc=%h cyc=%0d got valid=%b ready=%b res=%h tk=%b fl=%b required valid=1 ready=0 res=%h tk=%b fl=%b",
                         opc, i, rsp_valid, req_ready, rsp_result, rsp_taken, flags,
                         got.result, got.taken, got.flags);
            end
        end
        rsp_ready = 1'b1;
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL response opc=%h got res=%h tk=%b fl=%b required res=%h tk=%b fl=%b",
                     opc, got.result, got.taken, got.flags, e.result, e.taken, e.flags);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL complete opc=%h got valid=%b ready=%b required valid=0 ready=1", opc, rsp_valid, req_ready);
        end
        $display("op %h cond=%0d x=%h t=%h hold=%0d -> res=%h taken=%b flags=%b", opc, cond, x, t, hold,
                 got.result, got.taken, got.flags);
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_result, rsp_taken, flags, alu_op, alu_x, alu_t, alu_cy}
            !== {2'b10, 8'h00, 1'b0, 3'b000, 5'b0, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got ready=%b valid=%b res=%h tk=%b fl=%b op=%b x=%h t=%h cy=%b required all zero with ready=1",
                     req_ready, rsp_valid, rsp_result, rsp_taken, flags, alu_op, alu_x, alu_t, alu_cy);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        $display("reset released");
    endtask

    task automatic test_add;
        run_op(4'h0, 3'd0, 8'h7F, 8'h01, 0, 1'b0);
        total++;
        if ({rsp_result, flags} !== {8'h80, 3'b100}) begin
            bad++;
            $display("FAIL add_7f_01 got res=%h fl=%b required res=80 fl=100", rsp_result, flags);
        end
    endtask

    task automatic test_sub_jcc;
        run_op(4'h2, 3'd0, 8'h05, 8'h05, 0, 1'b0);
        total++;
        if ({rsp_result, flags} !== {8'h00, 3'b011}) begin
            bad++;
            $display("FAIL sub_05_05 got res=%h fl=%b required res=00 fl=011", rsp_result, flags);
        end
        run_op(4'hF, 3'd1, 8'h33, 8'h44, 0, 1'b0);
        total++;
        if ({rsp_taken, flags, rsp_result} !== {1'b1, 3'b011, 8'h00}) begin
            bad++;
            $display("FAIL jcc_z got tk=%b fl=%b res=%h required tk=1 fl=011 res=00", rsp_taken, flags, rsp_result);
        end
        run_op(4'hF, 3'd2, 8'h00, 8'h00, 0, 1'b0);
        total++;
        if ({rsp_taken, flags} !== {1'b0, 3'b011}) begin
            bad++;
            $display("FAIL jcc_nz got tk=%b fl=%b required tk=0 fl=011", rsp_taken, flags);
        end
    endtask

    task automatic test_cmp;
        run_op(4'h6, 3'd0, 8'hAA, 8'h00, 0, 1'b0);
        run_op(4'hE, 3'd0, 8'h10, 8'h20, 0, 1'b0);
        total++;
        if ({rsp_result, flags, rsp_taken} !== {8'hAA, 3'b100, 1'b0}) begin
            bad++;
            $display("FAIL cmp_10_20 got res=%h fl=%b tk=%b required res=AA fl=100 tk=0", rsp_result, flags, rsp_taken);
        end
    endtask

    task automatic test_shift;
        run_op(4'hC, 3'd0, 8'h81, 8'h00, 0, 1'b0);
        total++;
        if ({rsp_result, flags} !== {8'h02, 3'b001}) begin
            bad++;
            $display("FAIL shl_81 got res=%h fl=%b required res=02 fl=001", rsp_result, flags);
        end
        run_op(4'hD, 3'd0, 8'h00, 8'h00, 0, 1'b0);
        total++;
        if (rsp_result !== 8'h01) begin
            bad++;
            $display("FAIL rcl_00 got res=%h required 01", rsp_result);
        end
    endtask

    task automatic test_backpressure;
        run_op(4'h4, 3'd0, 8'hF0, 8'h3C, 3, 1'b0);
        total++;
        if (sb.size() != 0 || rsp_result !== 8'h30) begin
            bad++;
            $display("FAIL backpressure got res=%h pending=%0d required res=30 pending=0", rsp_result, sb.size());
        end
    endtask

    task automatic test_flag_clr;
        run_op(4'h2, 3'd0, 8'h01, 8'h02, 0, 1'b0);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr  = 1'b0;
        mdl_flags = 3'b000;
        total++;
        if (flags !== 3'b000) begin
            bad++;
            $display("FAIL flag_clr_idle got fl=%b required 000", flags);
        end
        run_op(4'h0, 3'd0, 8'h80, 8'h80, 0, 1'b1);
        total++;
        if ({rsp_result, flags} !== {8'h00, 3'b000}) begin
            bad++;
            $display("FAIL flag_clr_priority got res=%h fl=%b required res=00 fl=000", rsp_result, flags);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            run_op(4'(i), 3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        req_opc   = 4'h0;
        req_x     = 8'h11;
        req_t     = 8'h22;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (alu_op !== 5'b01000) begin
            bad++;
            $display("FAIL reset_mid_exec got op=%b required 01000", alu_op);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_result, rsp_taken, flags, alu_op, alu_x, alu_t, alu_cy}
            !== {2'b10, 8'h00, 1'b0, 3'b000, 5'b0, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_values got ready=%b valid=%b res=%h tk=%b fl=%b op=%b x=%h t=%h cy=%b required all zero with ready=1",
                     req_ready, rsp_valid, rsp_result, rsp_taken, flags, alu_op, alu_x, alu_t, alu_cy);
        end
        mdl_flags  = 3'b000;
        mdl_result = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_no_response got valid_cycles=%0d ready=%b required 0 and ready=1", seen, req_ready);
        end
        @(posedge clk);
        #1;
        run_op(4'h8, 3'd0, 8'hFF, 8'h00, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_jcc();
        test_cmp();
        test_shift();
        test_backpressure();
        test_flag_clr();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: request present.
REQ-004 SHALL have port req_ready, output, 1 bit: request accepted when req_valid && req_ready.
REQ-005 SHALL have port req_opc, input, 4 bits: instruction code.
REQ-006 SHALL have port req_cond, input, 3 bits: branch condition, JCC only.
REQ-007 SHALL have ports req_x and req_t, inputs, 8 bits each: operands.
REQ-008 SHALL have ports alu_x and alu_t, outputs, 8 bits each: drive the ALU x and t inputs.
REQ-009 SHALL have ports alu_cy, output, 1 bit, and alu_op, output, 5 bits: drive the ALU cy and alu_op inputs.
REQ-010 SHALL have ports alu_flag, input, 3 bits, {S,Z,Cy}, and alu_result, input, 8 bits: combinational ALU response.
REQ-011 SHALL have ports rsp_valid, output, 1 bit, and rsp_ready, input, 1 bit: response handshake.
REQ-012 SHALL have ports rsp_result, output, 8 bits; rsp_taken, output, 1 bit; flags, output, 3 bits, {S,Z,Cy}, the architectural flag register.
REQ-013 SHALL have port flag_clr, input, 1 bit: synchronous clear of the flag register.

Function
REQ-014 SHALL use states IDLE, EXEC, DONE; IDLE->EXEC on accept; EXEC->DONE unconditionally; DONE->IDLE when rsp_ready=1.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 SHALL register req_opc, req_cond, req_x and req_t on accept; operands SHALL NOT change until the next accept.
REQ-017 SHALL map opcodes to alu_op: 0 ADD 01000, 1 ADC 01010, 2 SUB 01011, 3 SBC 01101, 4 AND 10000, 5 OR 10001, 6 XOR 10010, 7 NOT 10011, 8 INC 01110, 9 DEC 01111, A SHR 11000, B RCR 11001, C SHL 11011, D RCL 11010, E CMP 01011, F JCC 00000.
REQ-018 SHALL drive the mapped alu_op, registered operands, and alu_cy=flags[0] only in EXEC; otherwise alu_op=00000, alu_x=alu_t=0, alu_cy=0.
REQ-019 SHALL capture alu_result into rsp_result at the end of EXEC for opcodes 0-D; CMP and JCC SHALL leave rsp_result unchanged.
REQ-020 SHALL load flags from alu_flag at the end of EXEC for opcodes 0-E; JCC SHALL leave flags unchanged.
REQ-021 SHALL evaluate rsp_taken at the end of EXEC for JCC from the pre-update flags: cond 0 always, 1 Z, 2 !Z, 3 Cy, 4 !Cy, 5 S, 6 !S, 7 never; non-JCC opcodes SHALL set rsp_taken=0.
REQ-022 SHALL assert rsp_valid exactly in DONE; latency is 2 cycles from accept to rsp_valid.
REQ-023 SHALL hold rsp_result, rsp_taken and flags stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL give flag_clr priority over any same-cycle flag load, resulting in flags=000.
REQ-025 SHALL return to IDLE and raise req_ready in the cycle after rsp_valid && rsp_ready, with no accept in the same cycle as response completion.

Reset
REQ-026 SHALL, on rst_n=0 in any state (including mid-EXEC or DONE), immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_taken=0, flags=000, alu_op=00000, alu_x=alu_t=0, alu_cy=0.
REQ-027 SHALL accept the first request no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-028 SHALL place opcode constants, alu_op encodings, condition codes and the state enum in shared package alu_ctrl_pkg.
REQ-029 SHALL implement condition evaluation in one sub-module, alu_cond (inputs: flags and cond; output: taken).

Verification
REQ-030 SHALL cover ADD: x=7F, t=01 -> rsp_result=80, flags=100, rsp_valid 2 cycles after accept.
REQ-031 SHALL cover SUB then JCC: SUB x=05, t=05 -> result 00, flags=011; then JCC cond=1 -> rsp_taken=1, flags unchanged.
REQ-032 SHALL cover CMP: x=10, t=20 after result AA -> rsp_result stays AA, flags=100.
REQ-033 SHALL cover SHL: x=81 -> result 02, flags=001; then RCL x=00 -> alu_cy=1, result 01.
REQ-034 SHALL cover backpressure: rsp_ready=0 for 3 cycles -> outputs stable, req_ready=0, single response on release.
REQ-035 SHALL cover reset: rst_n pulsed during EXEC -> all outputs at reset values, no response issued.
